multi_flex_counter: RTL and testbench

//  Parametrised multi-channel successor to the single flexible counter: NUM_CH independent

---
 rtl/flex_counter_pkg.sv | 12 +
 rtl/flex_counter_channel.sv | 82 ++++++++
 rtl/multi_flex_counter.sv | 57 +++++
 tb/tb_multi_flex_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_counter_pkg.sv
// Shared types for the multi-channel flexible counter.
package flex_counter_pkg;

  // Encoding 11 is reserved and behaves as WRAP.
  typedef enum logic [1:0] {
    CM_WRAP    = 2'b00,
    CM_SAT     = 2'b01,
    CM_ONESHOT = 2'b10,
    CM_RSVD    = 2'b11
  } cnt_mode_t;

endpackage

// File: rtl/flex_counter_channel.sv
// One counter channel: count, flag, pulse and armed flops with clear > load > advance > hold.
// All outputs registered, 1 clk latency; ev is combinational for same-edge cascading.
module flex_counter_channel
  import flex_counter_pkg::*;
#(
  parameter int NUM_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  input  cnt_mode_t               mode,
  input  logic                    casc_in,
  output logic [NUM_CNT_BITS-1:0] count,
  output logic                    rollover_flag,
  output logic                    rollover_pulse,
  output logic                    armed,
  output logic                    ev
);

  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    flag_q, flag_d;
  logic                    pulse_q, pulse_d;
  logic                    armed_q, armed_d;
  logic                    r_nz, at_r, en_eff;

  assign r_nz   = (rollover_val != '0);
  assign at_r   = (count_q == rollover_val);
  assign en_eff = count_enable & armed_q & r_nz & casc_in;
  assign ev     = en_eff & at_r & ~clear & ~load;

  always_comb begin
    count_d = count_q;
    armed_d = armed_q;
    if (clear) begin
      count_d = '0;
      armed_d = 1'b1;
    end else if (load) begin
      count_d = load_val;
      armed_d = 1'b1;
    end else if (en_eff) begin
      if (at_r) begin
        case (mode)
          CM_SAT:     count_d = count_q;
          CM_ONESHOT: begin
            count_d = '0;
            armed_d = 1'b0;
          end
          // Legacy wrap restarts at 1, giving the sequence 1..R.
          default:    count_d = NUM_CNT_BITS'(1);
        endcase
      end else begin
        count_d = count_q + NUM_CNT_BITS'(1);
      end
    end
    flag_d  = r_nz & (count_d == rollover_val);
    pulse_d = ev;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      count_q <= count_d;
      flag_q  <= flag_d;
      pulse_q <= pulse_d;
      armed_q <= armed_d;
    end
  end

  assign count          = count_q;
  assign rollover_flag  = flag_q;
  assign rollover_pulse = pulse_q;
  assign armed          = armed_q;

endmodule

// File: rtl/multi_flex_counter.sv
// NUM_CH independent flexible counters, optionally cascaded through same-edge rollover events.
// Outputs registered, 1 clk latency; no backpressure, every edge is evaluated.
module multi_flex_counter
  import flex_counter_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int NUM_CNT_BITS = 8,
  parameter int CASCADE      = 0
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic [NUM_CH-1:0]                clear,
  input  logic [NUM_CH-1:0]                count_enable,
  input  logic [NUM_CH-1:0]                load,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0]   load_val,
  input  logic [NUM_CH*NUM_CNT_BITS-1:0]   rollover_val,
  input  logic [NUM_CH*2-1:0]              mode,
  output logic [NUM_CH*NUM_CNT_BITS-1:0]   count_out,
  output logic [NUM_CH-1:0]                rollover_flag,
  output logic [NUM_CH-1:0]                rollover_pulse,
  output logic [NUM_CH-1:0]                armed
);

  logic [NUM_CH-1:0] ev;
  // The last channel's event (and all of them without cascade) drives nothing further.
  logic              unused_ev;
  assign unused_ev = ^ev;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic casc;
    if (CASCADE != 0 && i > 0) begin : g_casc
      assign casc = ev[i-1];
    end else begin : g_free
      assign casc = 1'b1;
    end

    flex_counter_channel #(
      .NUM_CNT_BITS(NUM_CNT_BITS)
    ) u_ch (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (clear[i]),
      .count_enable  (count_enable[i]),
      .load          (load[i]),
      .load_val      (load_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_val  (rollover_val[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .mode          (cnt_mode_t'(mode[2*i +: 2])),
      .casc_in       (casc),
      .count         (count_out[i*NUM_CNT_BITS +: NUM_CNT_BITS]),
      .rollover_flag (rollover_flag[i]),
      .rollover_pulse(rollover_pulse[i]),
      .armed         (armed[i]),
      .ev            (ev[i])
    );
  end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Bench for multi_flex_counter: plain and cascaded instances share stimulus, checked against
// directed tables, hand sequences and a per-channel reference model.
module tb_multi_flex_counter;
  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int NW  = NCH * W;
  localparam int MOD = 1 << W;

  logic           clk, n_rst;
  logic [NCH-1:0] clear, count_enable, load;
  logic [NW-1:0]  load_val, rollover_val;
  logic [2*NCH-1:0] mode;
  logic [NW-1:0]  cnt0, cnt1;
  logic [NCH-1:0] flg0, flg1, pls0, pls1, arm0, arm1;

  multi_flex_counter #(.NUM_CH(NCH), .NUM_CNT_BITS(W), .CASCADE(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable), .load(load),
    .load_val(load_val), .rollover_val(rollover_val), .mode(mode),
    .count_out(cnt0), .rollover_flag(flg0), .rollover_pulse(pls0), .armed(arm0));

  multi_flex_counter #(.NUM_CH(NCH), .NUM_CNT_BITS(W), .CASCADE(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(count_enable), .load(load),
    .load_val(load_val), .rollover_val(rollover_val), .mode(mode),
    .count_out(cnt1), .rollover_flag(flg1), .rollover_pulse(pls1), .armed(arm1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
  endfunction

  // Reference model: index 0 = independent channels, 1 = cascaded chain.
  int m_cnt[2][NCH];
  bit m_arm[2][NCH];
  bit m_flag[2][NCH];
  bit m_pulse[2][NCH];

  function automatic void model_reset();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NCH; i++) begin
        m_cnt[c][i] = 0; m_arm[c][i] = 1; m_flag[c][i] = 0; m_pulse[c][i] = 0;
      end
  endfunction

  function automatic void model_step(int c);
    bit prev_ev = 0;
    for (int i = 0; i < NCH; i++) begin
      int r   = int'(rollover_val[i*W +: W]);
      int md  = int'(mode[2*i +: 2]);
      int cur = m_cnt[c][i];
      int nxt = cur;
      bit go, fired;
      go    = count_enable[i] && m_arm[c][i] && r != 0 && (c == 0 || i == 0 || prev_ev);
      fired = go && cur == r && !clear[i] && !load[i];
      if (clear[i]) begin
        nxt = 0; m_arm[c][i] = 1;
      end else if (load[i]) begin
        nxt = int'(load_val[i*W +: W]); m_arm[c][i] = 1;
      end else if (go) begin
        if (cur != r) nxt = (cur + 1) % MOD;
        else if (md == 1) nxt = r;
        else if (md == 2) begin nxt = 0; m_arm[c][i] = 0; end
        else nxt = 1;
      end
      m_cnt[c][i]   = nxt;
      m_flag[c][i]  = (r != 0) && (nxt == r);
      m_pulse[c][i] = fired;
      prev_ev = fired;
    end
  endfunction

  function automatic logic [NW-1:0] exp_cnt(int c);
    logic [NW-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i*W +: W] = W'(m_cnt[c][i]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_bits(int c, int which);
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++)
      v[i] = (which == 0) ? m_flag[c][i] : (which == 1) ? m_pulse[c][i] : m_arm[c][i];
    return v;
  endfunction

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check("m0_cnt", 32'(cnt0), 32'(exp_cnt(0)));
    check("m0_flag", 32'(flg0), 32'(exp_bits(0, 0)));
    check("m0_pulse", 32'(pls0), 32'(exp_bits(0, 1)));
    check("m0_armed", 32'(arm0), 32'(exp_bits(0, 2)));
    check("m1_cnt", 32'(cnt1), 32'(exp_cnt(1)));
    check("m1_flag", 32'(flg1), 32'(exp_bits(1, 0)));
    check("m1_pulse", 32'(pls1), 32'(exp_bits(1, 1)));
    check("m1_armed", 32'(arm1), 32'(exp_bits(1, 2)));
  endtask

  typedef struct {
    int clr, ld, en, lv, rv, md;
    int cnt, flg, pls, arm;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int clr, int ld, int en, int lv, int rv, int md,
                              int cnt, int flg, int pls, int arm);
    vec_t v;
    v.clr = clr; v.ld = ld; v.en = en; v.lv = lv; v.rv = rv; v.md = md;
    v.cnt = cnt; v.flg = flg; v.pls = pls; v.arm = arm;
    tbl.push_back(v);
  endfunction

  int casc_c0[7] = '{1, 2, 3, 1, 2, 3, 1};
  int casc_c1[7] = '{0, 0, 0, 1, 1, 1, 2};

  initial begin
    n_rst = 1'b0;
    clear = '0; count_enable = '0; load = '0;
    load_val = '0; rollover_val = '0; mode = '0;
    model_reset();
    #12;
    check("rst_cnt0", 32'(cnt0), 32'h0);
    check("rst_cnt1", 32'(cnt1), 32'h0);
    check("rst_flag", 32'({flg0, flg1}), 32'h0);
    check("rst_pulse", 32'({pls0, pls1}), 32'h0);
    check("rst_armed", 32'({arm0, arm1}), 32'hFF);
    n_rst = 1'b1;

    // Channel 0 only; other channels idle with R=0.
    // clr ld en lv rv md | cnt flg pls arm
    for (int k = 1; k <= 4; k++) add(0, 0, 1, 0, 5, 0, k, 0, 0, 1);
    add(0, 0, 1, 0, 5, 0, 5, 1, 0, 1);
    add(0, 0, 1, 0, 5, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 5, 0, 2, 0, 0, 1);
    add(1, 0, 1, 0, 5, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 1, 1, 0, 0, 1);
    add(0, 0, 1, 0, 3, 1, 2, 0, 0, 1);
    add(0, 0, 1, 0, 3, 1, 3, 1, 0, 1);
    add(0, 0, 1, 0, 3, 1, 3, 1, 1, 1);
    add(0, 0, 1, 0, 3, 1, 3, 1, 1, 1);
    add(1, 0, 0, 0, 3, 2, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 2, 1, 0, 0, 1);
    add(0, 0, 1, 0, 3, 2, 2, 0, 0, 1);
    add(0, 0, 1, 0, 3, 2, 3, 1, 0, 1);
    add(0, 0, 1, 0, 3, 2, 0, 0, 1, 0);
    add(0, 0, 1, 0, 3, 2, 0, 0, 0, 0);
    add(0, 0, 1, 0, 3, 2, 0, 0, 0, 0);
    add(0, 1, 1, 2, 3, 2, 2, 0, 0, 1);
    add(0, 0, 1, 0, 3, 2, 3, 1, 0, 1);
    add(1, 1, 1, 9, 9, 0, 0, 0, 0, 1);
    add(0, 1, 1, 9, 9, 0, 9, 1, 0, 1);
    add(0, 0, 1, 0, 9, 0, 1, 0, 1, 1);
    add(0, 1, 0, 14, 3, 0, 14, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 15, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 2, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 3, 1, 0, 1);
    add(0, 0, 1, 0, 3, 0, 1, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 1, 1, 5, 0, 0, 5, 0, 0, 1);
    add(0, 0, 1, 0, 7, 0, 6, 0, 0, 1);
    add(0, 0, 1, 0, 6, 0, 1, 0, 1, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      clear        = NCH'(tbl[k].clr);
      load         = NCH'(tbl[k].ld);
      count_enable = NCH'(tbl[k].en);
      load_val     = NW'(tbl[k].lv);
      rollover_val = NW'(tbl[k].rv);
      mode         = (2*NCH)'(tbl[k].md);
      step();
      check($sformatf("tbl%0d_cnt", k), 32'(cnt0[W-1:0]), 32'(tbl[k].cnt));
      check($sformatf("tbl%0d_flag", k), 32'(flg0[0]), 32'(tbl[k].flg));
      check($sformatf("tbl%0d_pulse", k), 32'(pls0[0]), 32'(tbl[k].pls));
      check($sformatf("tbl%0d_armed", k), 32'(arm0[0]), 32'(tbl[k].arm));
    end

    // Cascade: R0=3, R1=2; ch1 must step only on ch0's rollover edges.
    clear = '1; load = '0; count_enable = '0; mode = '0;
    step();
    clear = '0;
    rollover_val = '0;
    rollover_val[0 +: W] = W'(3);
    rollover_val[W +: W] = W'(2);
    count_enable = 4'b0011;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("casc%0d_c0", k), 32'(cnt1[0 +: W]), 32'(casc_c0[k]));
      check($sformatf("casc%0d_c1", k), 32'(cnt1[W +: W]), 32'(casc_c1[k]));
      check($sformatf("casc%0d_f1", k), 32'(flg1[1]), (k == 6) ? 32'd1 : 32'd0);
    end

    // Async reset in the middle of a count.
    clear = '1; count_enable = '0;
    step();
    clear = '0;
    rollover_val = NW'(10);
    load = 4'b0001; load_val = NW'(7);
    step();
    check("mid_cnt7", 32'(cnt0[W-1:0]), 32'd7);
    load = '0; count_enable = 4'b0001;
    #3 n_rst = 1'b0;
    #1;
    check("arst_cnt", 32'({cnt0, cnt1}), 32'h0);
    check("arst_flag_pulse", 32'({flg0, flg1, pls0, pls1}), 32'h0);
    check("arst_armed", 32'({arm0, arm1}), 32'hFF);
    model_reset();
    #2 n_rst = 1'b1;
    step();
    check("arst_resume", 32'(cnt0[W-1:0]), 32'd1);

    // R=0 with enable held: frozen.
    rollover_val = '0;
    count_enable = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("r0_frozen", 32'(cnt0[W-1:0]), 32'd1);
      check("r0_quiet", 32'({flg0, pls0}), 32'h0);
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NCH; i++) begin
        clear[i]        = ($urandom_range(19) == 0);
        load[i]         = ($urandom_range(19) == 0);
        count_enable[i] = ($urandom_range(3) != 0);
        load_val[i*W +: W] = W'($urandom_range(MOD - 1));
        if ($urandom_range(31) == 0) rollover_val[i*W +: W] = W'($urandom_range(MOD - 1));
        if ($urandom_range(31) == 0) mode[2*i +: 2] = 2'($urandom_range(3));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
